// File: rtl/pl_pkg.sv
// Shared pipeline constants and types for the writeback stage.
package pl_pkg;

  localparam int DATA_W     = 16;
  localparam int NREG       = 16;
  localparam int REG_AW     = $clog2(NREG);
  localparam int MEM_TO_CYC = 15;

  localparam logic [3:0] OPC_NOP = 4'h0;

  localparam logic RF_SEL_EXU = 1'b0;
  localparam logic RF_SEL_MEM = 1'b1;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// NREG x DATA_W register file: one synchronous write port and two combinational
// read ports. R0 always reads as zero, and a same-cycle write is bypassed to the reads.
module regfile_2r1w
  import pl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0)                        rs1_data = '0;
    else if (wr_en && (wr_addr == rs1_addr))   rs1_data = wr_data;

    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0)                        rs2_data = '0;
    else if (wr_en && (wr_addr == rs2_addr))   rs2_data = wr_data;
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: commits ALU/load results, waits (bounded) for late load data.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
//
// state    | meaning
// IDLE     | EX/WB instruction processed this cycle
// WAIT_MEM | load pending on mem_rvalid; upstream held, EX/WB inputs ignored
module wb_stage
  import pl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode_wb,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic [DATA_W-1:0] exu_data_wb,
  input  logic              rf_wr_wb,
  input  logic              rf_wr_sel_wb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              wb_stall,
  output logic              wb_wr_en,
  output logic [REG_AW-1:0] wb_wr_addr,
  output logic [DATA_W-1:0] wb_wr_data,
  output logic              wb_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_TO_CYC + 1);
  // The IDLE cycle that detects the miss is the first stall cycle, so the
  // timeout fires one count early to keep total stall at MEM_TO_CYC cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TO_CYC - 1);

  wb_state_t         state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [REG_AW-1:0] rd_lat, rd_lat_nxt;
  logic              wr_req, stall, err_set;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    rd_lat_nxt   = rd_lat;
    wr_req       = 1'b0;
    stall        = 1'b0;
    err_set      = 1'b0;
    wb_wr_addr   = rd_wb;
    wb_wr_data   = exu_data_wb;

    unique case (state)
      IDLE: begin
        if ((opcode_wb != OPC_NOP) && rf_wr_wb) begin
          if (rf_wr_sel_wb == RF_SEL_MEM) begin
            wb_wr_data = mem_rdata;
            if (mem_rvalid) begin
              wr_req = 1'b1;
            end else begin
              stall        = 1'b1;
              state_nxt    = WAIT_MEM;
              wait_cnt_nxt = '0;
              rd_lat_nxt   = rd_wb;
            end
          end else begin
            wr_req = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        wb_wr_addr = rd_lat;
        wb_wr_data = mem_rdata;
        if (mem_rvalid) begin
          wr_req    = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall        = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    wb_stall = stall && rst_n;
    wb_wr_en = wr_req && rst_n && (wb_wr_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rd_lat   <= '0;
      wb_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      rd_lat   <= rd_lat_nxt;
      if (err_set) wb_err <= 1'b1;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // In WAIT_MEM a non-stalled cycle is always an exit (data or timeout).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (!stall && ((state == WAIT_MEM) || (opcode_wb != OPC_NOP))) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

  regfile_2r1w u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wb_wr_en),
    .wr_addr  (wb_wr_addr),
    .wr_data  (wb_wr_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (default and WB_RETIRE_CNT_EN builds).
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode_wb;
  logic [3:0]  rd_wb;
  logic [15:0] exu_data_wb;
  logic        rf_wr_wb;
  logic        rf_wr_sel_wb;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic        wb_stall;
  logic        wb_wr_en;
  logic [3:0]  wb_wr_addr;
  logic [15:0] wb_wr_data;
  logic        wb_err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_wb    (opcode_wb),
    .rd_wb        (rd_wb),
    .exu_data_wb  (exu_data_wb),
    .rf_wr_wb     (rf_wr_wb),
    .rf_wr_sel_wb (rf_wr_sel_wb),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .wb_stall     (wb_stall),
    .wb_wr_en     (wb_wr_en),
    .wb_wr_addr   (wb_wr_addr),
    .wb_wr_data   (wb_wr_data),
    .wb_err       (wb_err)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt)
`endif
  );

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [15:0] exu,
                       input logic wr, input logic sel, input logic [15:0] rdata,
                       input logic rvalid);
    opcode_wb    = op;
    rd_wb        = rd;
    exu_data_wb  = exu;
    rf_wr_wb     = wr;
    rf_wr_sel_wb = sel;
    mem_rdata    = rdata;
    mem_rvalid   = rvalid;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    rs1_addr = 4'h0;
    rs2_addr = 4'h0;
    next_cycle();
    next_cycle();
    for (int a = 0; a < 16; a++) begin
      rs1_addr = 4'(a);
      rs2_addr = 4'(15 - a);
      #1;
      checks++;
      if (rs1_data !== 16'h0000 || rs2_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read a=%0d rs1=%h rs2=%h expected 0000", a, rs1_data, rs2_data);
      end
    end
    checks++;
    if (wb_stall !== 1'b0 || wb_err !== 1'b0 || wb_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl stall=%b err=%b wr_en=%b expected 0 0 0", wb_stall, wb_err, wb_wr_en);
    end
    rst_n = 1'b1;
    next_cycle();
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_retire got %0d expected 0", retire_cnt);
    end
`endif
  endtask

  task automatic test_alu_bypass();
    drive(4'h1, 4'd3, 16'hA5A5, 1'b1, 1'b0, 16'h0, 1'b0);
    rs1_addr = 4'd3;
    rs2_addr = 4'd3;
    @(negedge clk);
    checks++;
    if (rs1_data !== 16'hA5A5 || rs2_data !== 16'hA5A5) begin
      errors++;
      $display("FAIL alu_bypass rs1=%h rs2=%h expected a5a5", rs1_data, rs2_data);
    end
    checks++;
    if (wb_wr_en !== 1'b1 || wb_wr_addr !== 4'd3 || wb_wr_data !== 16'hA5A5 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_wr en=%b addr=%0d data=%h stall=%b expected 1 3 a5a5 0",
               wb_wr_en, wb_wr_addr, wb_wr_data, wb_stall);
    end
    next_cycle();
    drive(4'h0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (rs1_data !== 16'hA5A5 || wb_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL alu_array rs1=%h wr_en=%b expected a5a5 0", rs1_data, wb_wr_en);
    end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL alu_retire got %0d expected 1", retire_cnt);
    end
`endif
    next_cycle();
  endtask

  task automatic test_r0();
    drive(4'h1, 4'd0, 16'hFFFF, 1'b1, 1'b0, 16'h0, 1'b0);
    rs1_addr = 4'd0;
    @(negedge clk);
    checks++;
    if (wb_wr_en !== 1'b0 || rs1_data !== 16'h0000) begin
      errors++;
      $display("FAIL r0_write wr_en=%b rs1=%h expected 0 0000", wb_wr_en, rs1_data);
    end
    next_cycle();
    drive(4'h0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (rs1_data !== 16'h0000) begin
      errors++;
      $display("FAIL r0_read rs1=%h expected 0000", rs1_data);
    end
    next_cycle();
  endtask

  task automatic test_load_wait();
    drive(4'h2, 4'd5, 16'h0, 1'b1, 1'b1, 16'h0, 1'b0);
    rs1_addr = 4'd5;
    rs2_addr = 4'd9;
    for (int k = 0; k < 4; k++) begin
      if (k >= 1) begin
        rd_wb        = 4'd9;
        rf_wr_sel_wb = 1'b0;
        exu_data_wb  = 16'hBEEF;
      end
      if (k == 3) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1234;
      end
      @(negedge clk);
      checks++;
      if (k < 3) begin
        if (wb_stall !== 1'b1 || wb_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL load_wait k=%0d stall=%b wr_en=%b expected 1 0", k, wb_stall, wb_wr_en);
        end
      end else begin
        if (wb_stall !== 1'b0 || wb_wr_en !== 1'b1 || wb_wr_addr !== 4'd5 ||
            wb_wr_data !== 16'h1234 || rs1_data !== 16'h1234) begin
          errors++;
          $display("FAIL load_done stall=%b en=%b addr=%0d data=%h rs1=%h expected 0 1 5 1234 1234",
                   wb_stall, wb_wr_en, wb_wr_addr, wb_wr_data, rs1_data);
        end
      end
      next_cycle();
    end
    drive(4'h0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (rs1_data !== 16'h1234 || rs2_data !== 16'h0000 || wb_wr_en !== 1'b0 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_after r5=%h r9=%h en=%b stall=%b expected 1234 0000 0 0",
               rs1_data, rs2_data, wb_wr_en, wb_stall);
    end
    next_cycle();
  endtask

  task automatic test_timeout_race();
    drive(4'h2, 4'd8, 16'h0, 1'b1, 1'b1, 16'h0, 1'b0);
    rs1_addr = 4'd8;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h8888;
      end
      @(negedge clk);
      checks++;
      if (k < 15) begin
        if (wb_stall !== 1'b1) begin
          errors++;
          $display("FAIL race_stall k=%0d stall=%b expected 1", k, wb_stall);
        end
      end else if (wb_stall !== 1'b0 || wb_wr_en !== 1'b1 || wb_wr_addr !== 4'd8) begin
        errors++;
        $display("FAIL race_write stall=%b en=%b addr=%0d expected 0 1 8", wb_stall, wb_wr_en, wb_wr_addr);
      end
      next_cycle();
    end
    drive(4'h0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (rs1_data !== 16'h8888 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL race_result r8=%h err=%b expected 8888 0", rs1_data, wb_err);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    int  stall_cycles;
    bit  done;
    drive(4'h1, 4'd7, 16'h7777, 1'b1, 1'b0, 16'h0, 1'b0);
    next_cycle();
    drive(4'h2, 4'd7, 16'h0, 1'b1, 1'b1, 16'h0, 1'b0);
    stall_cycles = 0;
    done = 1'b0;
    for (int k = 0; k < 25 && !done; k++) begin
      @(negedge clk);
      if (wb_stall === 1'b1) begin
        stall_cycles++;
      end else begin
        done = 1'b1;
        checks++;
        if (wb_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL timeout_nowrite wr_en=%b expected 0", wb_wr_en);
        end
      end
      next_cycle();
    end
    checks++;
    if (!done || stall_cycles != 15) begin
      errors++;
      $display("FAIL timeout_len stall_cycles=%0d ended=%0d expected 15 1", stall_cycles, done);
    end
    drive(4'h0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (wb_err !== 1'b1 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err err=%b stall=%b expected 1 0", wb_err, wb_stall);
    end
    next_cycle();
    drive(4'h1, 4'd2, 16'h0202, 1'b1, 1'b0, 16'h0, 1'b0);
    next_cycle();
    drive(4'h0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    rs1_addr = 4'd7;
    rs2_addr = 4'd2;
    @(negedge clk);
    checks++;
    if (wb_err !== 1'b1 || rs1_data !== 16'h7777 || rs2_data !== 16'h0202) begin
      errors++;
      $display("FAIL timeout_sticky err=%b r7=%h r2=%h expected 1 7777 0202", wb_err, rs1_data, rs2_data);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    drive(4'h2, 4'd6, 16'h0, 1'b1, 1'b1, 16'h0, 1'b0);
    rs1_addr = 4'd6;
    @(negedge clk);
    checks++;
    if (wb_stall !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_enter stall=%b expected 1", wb_stall);
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_stall !== 1'b0 || wb_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_during stall=%b wr_en=%b expected 0 0", wb_stall, wb_wr_en);
    end
    next_cycle();
    rst_n = 1'b1;
    drive(4'h0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h6666, 1'b1);
    @(negedge clk);
    checks++;
    if (wb_wr_en !== 1'b0 || wb_stall !== 1'b0 || rs1_data !== 16'h0000 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_after en=%b stall=%b r6=%h err=%b expected 0 0 0000 0",
               wb_wr_en, wb_stall, rs1_data, wb_err);
    end
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (rs1_data !== 16'h0000) begin
      errors++;
      $display("FAIL rstwait_r6 r6=%h expected 0000", rs1_data);
    end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rstwait_retire got %0d expected 0", retire_cnt);
    end
`endif
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_alu_bypass();
    test_r0();
    test_load_wait();
    test_timeout_race();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage directly downstream of the EX/WB pipeline register. It commits ALU results or memory load data into a 16-entry x 16-bit register file and serves two combinational read ports to the decode stage, with same-cycle write bypass. Loads whose memory data is late are held in a small wait FSM, which stalls the upstream pipeline and bounds the wait with a timeout.

Parameters:
DATA_W, 16, datapath and register width
NREG, 16, number of architectural registers; address width is clog2(NREG)
MEM_TO_CYC, 15, maximum WAIT_MEM cycles before the load is abandoned

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset; sampled on rising clk
opcode_wb  in  4  opcode from EX/WB register; OPC_NOP (4'h0) marks a bubble
rd_wb  in  4  destination register
exu_data_wb  in  DATA_W  ALU result
rf_wr_wb  in  1  instruction writes the register file
rf_wr_sel_wb  in  1  0 = exu_data_wb, 1 = mem_rdata (load)
mem_rdata  in  DATA_W  data-memory read data
mem_rvalid  in  1  mem_rdata valid this cycle
rs1_addr  in  4  read port 1 address
rs2_addr  in  4  read port 2 address
rs1_data  out  DATA_W  read port 1 data (combinational)
rs2_data  out  DATA_W  read port 2 data (combinational)
wb_stall  out  1  hold EX/WB and all upstream stages this cycle
wb_wr_en  out  1  register-file write this cycle (also a forwarding source)
wb_wr_addr  out  4  write address
wb_wr_data  out  DATA_W  write data
wb_err  out  1  sticky load-timeout flag

Behaviour:
- Reset (rst_n=0 at posedge): all NREG registers = 0, state = IDLE, wait counter = 0, wb_err = 0. During reset, wb_wr_en = 0 and wb_stall = 0.
- Reset mid-WAIT_MEM: the pending load is dropped and no write occurs.
- R0 is hardwired to zero:
  - Reads of R0 return 0.
  - Writes to R0 are suppressed; wb_wr_en = 0 when the address is 0.
- ALU write (rf_wr_wb=1, rf_wr_sel_wb=0) in IDLE:
  - wb_wr_en = 1, wb_wr_addr = rd_wb, wb_wr_data = exu_data_wb.
  - Register updates at the same posedge; zero added latency.
- Load (rf_wr_wb=1, rf_wr_sel_wb=1) in IDLE:
  - mem_rvalid = 1: write mem_rdata to rd_wb this cycle, no stall.
  - mem_rvalid = 0: wb_stall = 1, latch rd_wb, go to WAIT_MEM, counter = 0.
- WAIT_MEM:
  - EX/WB inputs are ignored; upstream is held.
  - Each cycle with mem_rvalid = 0: wb_stall = 1, counter increments.
  - mem_rvalid = 1: write mem_rdata to the latched rd, wb_stall = 0 this cycle, return to IDLE.
  - Counter reaches MEM_TO_CYC with no valid: no write, wb_err set (sticky until reset), wb_stall = 0, return to IDLE.
  - mem_rvalid on the timeout cycle: the valid wins and the write occurs, no error.
- rf_wr_wb = 0 or OPC_NOP: no write, no stall.
- Stall is combinational: (IDLE & load & !mem_rvalid) | (WAIT_MEM & !mem_rvalid & !timeout).
- Reads:
  - rsN_data = 0 if rsN_addr = 0.
  - Else wb_wr_data if wb_wr_en and wb_wr_addr = rsN_addr (write-through bypass).
  - Else the register contents.
  - Both ports may read the same address.

Optional Feature:
WB_RETIRE_CNT_EN
- Defined:
  - Adds output retire_cnt[31:0], reset 0.
  - Increments by 1 on every cycle where wb_stall = 0, the state is IDLE or a WAIT_MEM exit, and the instruction is not OPC_NOP.
  - Timed-out loads also count.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: no port, no counter logic.

Decomposition:
- Package pl_pkg:
  - DATA_W, REG_AW, OPC_NOP
  - wb_state_t enum {IDLE, WAIT_MEM}
  - RF_SEL_EXU = 0, RF_SEL_MEM = 1
- One sub-module: regfile_2r1w. It holds the NREG x DATA_W array, synchronous write, R0 suppression and bypass read muxes. The wb_stage top keeps the FSM, the wait counter, the write-source mux and the retire counter.

Test Plan:
- Reset then read all 16 addresses -> every rsN_data = 16'h0000; wb_stall = 0, wb_err = 0.
- ALU write rd=3, exu=16'hA5A5 with rs1_addr=3 in the same cycle -> rs1_data = 16'hA5A5 via bypass; the next cycle reads 16'hA5A5 from the array.
- Write rd=0, exu=16'hFFFF -> wb_wr_en = 0; rs1_addr=0 still reads 16'h0000.
- Load rd=5 with mem_rvalid low for 3 cycles, then high with 16'h1234 -> wb_stall high for exactly 3 cycles, R5 = 16'h1234, and the held EX/WB inputs during the wait cause no extra write.
- Load rd=7, mem_rvalid never asserted -> wb_stall high for MEM_TO_CYC cycles, then low; R7 unchanged; wb_err = 1 and remains 1 after later normal instructions.
- Reset asserted in cycle 2 of WAIT_MEM with mem_rvalid arriving the next cycle -> no write occurs, state = IDLE; with WB_RETIRE_CNT_EN, retire_cnt = 0.
